// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 B lines, combinational hit path,
// 4-word sequential line fill from the memory controller on a miss.
module icache #(
  parameter int LINE_NUM = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_en,
  input  logic [31:0] fetch_pc,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state_q, state_d;

  logic [LINE_NUM-1:0]    valid_arr;
  logic [TAG_W-1:0]       tag_arr  [LINE_NUM];
  logic [3:0][31:0]       data_arr [LINE_NUM];
  logic [31:0]            line_buf [3];
  logic [27:0]            fill_base;   // line address of the fill (byte address >> 4)
  logic [1:0]             cnt;

  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [1:0]       req_word;
  logic             hit, start_fill, word_done, last_word;
  logic             unused_pc;

  assign req_tag   = fetch_pc[31:4+IDX_W];
  assign req_idx   = fetch_pc[3+IDX_W:4];
  assign req_word  = fetch_pc[3:2];
  assign fill_tag  = fill_base[27:IDX_W];
  assign fill_idx  = fill_base[IDX_W-1:0];
  assign unused_pc = ^fetch_pc[1:0];

  always_comb begin
    hit         = fetch_en & valid_arr[req_idx] & (tag_arr[req_idx] == req_tag);
    instr_valid = hit;
    instr_out   = hit ? data_arr[req_idx][req_word] : '0;
  end

  // Hits are served in any state; only IDLE may launch a fill, so a miss that
  // coincides with the last word waits for the next IDLE edge.
  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    word_done  = 1'b0;
    last_word  = 1'b0;
    case (state_q)
      IDLE: if (fetch_en && !hit) begin
        start_fill = 1'b1;
        state_d    = FILL;
      end
      FILL: if (mem_done) begin
        word_done = 1'b1;
        if (cnt == 2'd3) begin
          last_word = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      valid_arr <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      if (start_fill) begin
        cnt      <= '0;
        mem_req  <= 1'b1;
        mem_addr <= {fetch_pc[31:4], 4'b0};
      end
      if (word_done) begin
        if (last_word) begin
          mem_req             <= 1'b0;
          valid_arr[fill_idx] <= 1'b1;
        end else begin
          cnt      <= cnt + 2'd1;
          mem_addr <= {fill_base, cnt + 2'd1, 2'b00};
        end
      end
    end
  end

  // Array and line buffer carry no reset; validity alone guards them.
  always_ff @(posedge clk) begin
    if (rdy && !rst) begin
      if (start_fill)
        fill_base <= fetch_pc[31:4];
      if (word_done && !last_word)
        line_buf[cnt] <= mem_data;
      if (word_done && last_word) begin
        tag_arr[fill_idx]  <= fill_tag;
        data_arr[fill_idx] <= {mem_data, line_buf[2], line_buf[1], line_buf[0]};
      end
    end
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache that answers the instruction fetcher's fetch requests and refills missing lines from the memory controller. It serves a hit combinationally in the cycle the request is presented. On a miss it runs a 4-word line fill, then serves the request from the array. It sits between the instruction fetcher (request side) and the memory controller (refill side).

## Interface
- `LINE_NUM`, default 64: number of lines (power of 2). Line size is fixed at 16 B (4 words); index width `IDX_W = log2(LINE_NUM)`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global ready; when 0, all state is frozen.
- `fetch_en`  in  1  request valid from the fetcher (its `rdy_to_fetch`), held until served.
- `fetch_pc`  in  32  requested byte address (its `pc_2icache`); bits [1:0] are ignored.
- `instr_valid`  out  1  combinational hit for the current request.
- `instr_out`  out  32  instruction word; meaningful only when `instr_valid`=1.
- `mem_req`  out  1  registered word-read request to the memory controller, level-held.
- `mem_addr`  out  32  registered word address of the current request, always word-aligned.
- `mem_done`  in  1  one-cycle pulse: the current word is returned on `mem_data`.
- `mem_data`  in  32  returned word.

## Operation
- Address split:
  - tag = `fetch_pc[31:4+IDX_W]`
  - index = `fetch_pc[3+IDX_W:4]`
  - word = `fetch_pc[3:2]`
- Storage per line: valid bit, tag, 4×32-bit data words.
- Hit rule: `instr_valid = fetch_en & valid[index] & (tag_arr[index]==tag)`.
  - On a hit, `instr_out = data[index][word]`.
  - On a miss, `instr_out = 0`.
- Hits are served in any state, including during a fill of another line.
- FSM states: IDLE, FILL.
- IDLE → FILL when `rdy & fetch_en & ~hit`. On that transition:
  - latch `fill_base = {fetch_pc[31:4], 4'b0}`;
  - set `cnt=0`, `mem_req<=1`, `mem_addr<=fill_base`.
- FILL, on `rdy & mem_done`:
  - store `mem_data` into line buffer slot `cnt`.
  - If `cnt<3`: `cnt<=cnt+1` and `mem_addr<=fill_base + 4*(cnt+1)`; `mem_req` stays 1, and the next cycle is a new request.
  - If `cnt==3`: write buffer (including this word), tag and valid=1 into `fill_base`'s index, set `mem_req<=0`, and return to IDLE.
- The fill uses only `fill_base`. Changes to `fetch_pc`/`fetch_en` during FILL, e.g. fetcher rollback, neither abort nor redirect the fill.
- On return to IDLE, the current request is re-evaluated against the updated array. A miss starts a new fill on the next edge.
- A line replacement overwrites the whole line (direct-mapped). There is no write path and no flush port.
- `rdy=0`: no state, array, `cnt`, `mem_req` or `mem_addr` change. A `mem_done` arriving while `rdy=0` is ignored; the memory controller shares `rdy` and does not pulse `mem_done` then.
- Reset: all valid bits cleared; state=IDLE; `cnt=0`; `mem_req=0`; `mem_addr=0`. Hence `instr_valid=0` and `instr_out=0` after reset. Data and tag arrays need not be cleared.
- `rst` has priority over `rdy`. Reset mid-fill drops the fill; the partially filled line stays invalid.

## Timing
- Hit latency: 0 cycles; `instr_valid` follows `fetch_en`/`fetch_pc` combinationally.
- Miss detected at edge E: `mem_req=1` from E+1.
- Each word completes on the edge where `mem_done=1`. `mem_addr` advances on that same edge.
- Last `mem_done` at edge F:
  - the array is written at F;
  - `mem_req=0` from F+1;
  - `instr_valid=1` from F+1 if the request is unchanged.
- Minimum miss penalty: 5 cycles (miss edge plus 4 single-cycle responses).
- `mem_addr` is stable while `mem_req=1` and no `mem_done` is pending.
- Simultaneous last `mem_done` and a new miss on the same edge: the new miss is not started until the following IDLE edge.

## Test plan
- Cold miss: reset, `fetch_en=1`, `fetch_pc=0x0`, memory returns 0xA0,0xA1,0xA2,0xA3 with 1-cycle latency.
  - `mem_addr` must step 0x0,0x4,0x8,0xC;
  - `mem_req` must drop after the 4th word;
  - next cycle `instr_valid=1`, `instr_out=0xA0`.
- Same-line hit: after the cold miss, `fetch_pc=0xA` → `instr_valid=1` in the same cycle with `instr_out=0xA2`, and `mem_req` stays 0.
- Conflict eviction with `LINE_NUM=64`:
  - `fetch_pc=0x400` misses and fills index 0 with tag 1;
  - then `fetch_pc=0x0` must miss and refill from 0x0.
- Redirect mid-fill:
  - during the word-1 wait, change `fetch_pc` to 0x100;
  - the fill of 0x0 completes unchanged, then a fill at 0x100 starts;
  - line 0x0 must afterwards hit.
- Stall: hold `rdy=0` for 3 cycles mid-fill → `cnt`, `mem_addr` and `mem_req` are unchanged, and the fill resumes correctly when `rdy=1`.
- Reset mid-fill: assert `rst` after word 1 → next cycle `mem_req=0`, `mem_addr=0`, FSM in IDLE; the same pc then misses and refills from word 0.
